mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15, is the maximum number of cycles waited for dmem_ack before an access aborts.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  one clock; reset is asynchronous and active-high.
REQ-004 ex_valid  in  1  execute stage presents an instruction this cycle.
REQ-005 ex_ready  out  1  mem_stage accepts an instruction this cycle; a transfer occurs when ex_valid && ex_ready.
REQ-006 instr  in  8  instruction word: opcode [7:6], rs [5:4], rt [3:2].
REQ-007 alu_result  in  8  ALU result, or effective address for LD/ST.
REQ-008 write_data  in  8  store data for ST.
REQ-009 dmem_req  out  1  data-memory request, held until dmem_ack or timeout.
REQ-010 dmem_we  out  1  1 = write (ST), 0 = read (LD).
REQ-011 dmem_addr  out  8  access address.
REQ-012 dmem_wdata  out  8  store data.
REQ-013 dmem_ack  in  1  memory completes the access; sampled only while dmem_req = 1.
REQ-014 dmem_rdata  in  8  read data, valid in the dmem_ack cycle.
REQ-015 wb_valid  out  1  one-cycle pulse: writeback record valid.
REQ-016 wb_we  out  1  register write enable, qualified by wb_valid.
REQ-017 wb_rd  out  2  destination register (rt).
REQ-018 wb_data  out  8  writeback value.
REQ-019 halted  out  1  sticky; HALT has retired.
REQ-020 mem_err  out  1  sticky; a data-memory access timed out.

Function
REQ-021 FSM states:
- IDLE: ex_ready = !halted.
- MEM: dmem_req = 1, ex_ready = 0.
REQ-022 On transfer in IDLE, the instruction fields and data are captured into internal registers.
REQ-023 Non-memory instructions return to IDLE; wb_valid pulses the cycle after the transfer (latency 1).
REQ-024 For opcode 01 with rs = 01 (LD) or rs = 10 (ST), the FSM goes to MEM; dmem_req rises the cycle after the transfer.
- dmem_addr = alu_result.
- dmem_we = (rs == 10).
- dmem_wdata = write_data.
- All held stable while in MEM.
REQ-025 In MEM, when dmem_ack = 1:
- dmem_req drops the next cycle.
- wb_valid pulses the next cycle.
- The FSM returns to IDLE.
- LD captures dmem_rdata into wb_data.
REQ-026 A wait counter clears on entry to MEM and increments every MEM cycle without ack.
REQ-027 When the counter reaches ACK_TIMEOUT, the access aborts:
- mem_err sets.
- wb_valid pulses with wb_we = 0.
- The FSM returns to IDLE.
REQ-028 An ack in the same cycle the counter reaches ACK_TIMEOUT counts as success; mem_err stays 0.
REQ-029 wb_we = 1 for R-type, ADDI (01/00), CMP (01/11), and a successful LD; wb_we = 0 for ST, jump (10), HALT (11) and an aborted access.
REQ-030 wb_data = alu_result for R-type, ADDI and CMP; dmem_rdata for LD; 0 otherwise.
REQ-031 wb_rd = captured rt for every retired instruction.
REQ-032 HALT retires with wb_valid = 1, wb_we = 0, and sets halted in the same cycle; afterwards ex_ready = 0 until reset.
REQ-033 Outputs with no explicit assignment this cycle are 0.
REQ-034 wb_valid never asserts in consecutive cycles for a single instruction.

Reset
REQ-035 Asserting rst forces the following immediately, regardless of clk:
- State = IDLE, counter = 0.
- Outputs 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_we, wb_rd, wb_data, halted, mem_err.
REQ-036 Reset during MEM abandons the access: no wb_valid and no mem_err for it.
REQ-037 ex_ready = 1 on the first cycle after rst deasserts.

Structure
REQ-038 Opcode constants (R, I, J, HALT), I-type sub-op constants (ADDI, LD, ST, CMP) and the FSM state enum belong in shared package cpu_pkg.
REQ-039 The timeout counter is sub-module mem_timeout_ctr, with inputs clear/enable and output expired.

Verification
REQ-040 ADD: instr = 0x04 (rt = 01), alu_result = 0x12 -> wb_valid next cycle, wb_we = 1, wb_rd = 01, wb_data = 0x12.
REQ-041 LD: instr = 0x58, alu_result = 0x20, dmem_ack 3 cycles after dmem_req rises with rdata = 0xA5.
- dmem_req = 1, dmem_we = 0, dmem_addr = 0x20 throughout.
- wb_data = 0xA5, wb_rd = 10, wb_we = 1.
- ex_ready = 0 during the wait.
REQ-042 ST: instr = 0x6C, alu_result = 0x31, write_data = 0x7E, ack after 1 cycle.
- dmem_we = 1, dmem_addr = 0x31, dmem_wdata = 0x7E.
- wb_valid with wb_we = 0.
REQ-043 LD with no ack -> wb_valid with wb_we = 0 after ACK_TIMEOUT MEM cycles; mem_err = 1; the next ADD retires normally.
REQ-044 HALT: instr = 0xC0 -> halted = 1, ex_ready = 0 permanently; subsequent ex_valid is ignored.
REQ-045 rst asserted mid-LD wait -> dmem_req = 0 immediately, no wb_valid, mem_err = 0; ex_ready = 1 after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode/sub-op constants and FSM state encoding for the CPU datapath.
// No logic; constants and a small decode helper only.
// Imported by mem_stage and its sub-modules.
package cpu_pkg;

  // Major opcodes, instr[7:6]
  localparam logic [1:0] OP_R    = 2'b00;
  localparam logic [1:0] OP_I    = 2'b01;
  localparam logic [1:0] OP_J    = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  // I-type sub-ops, carried in the rs field instr[5:4]
  localparam logic [1:0] SUB_ADDI = 2'b00;
  localparam logic [1:0] SUB_LD   = 2'b01;
  localparam logic [1:0] SUB_ST   = 2'b10;
  localparam logic [1:0] SUB_CMP  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEM  = 1'b1
  } mem_state_t;

  // True for instructions that need a data-memory access (LD or ST).
  function automatic logic is_mem_op(input logic [1:0] op, input logic [1:0] rs);
    return (op == OP_I) && ((rs == SUB_LD) || (rs == SUB_ST));
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for data-memory accesses; expired flags the last allowed wait cycle.
// Latency: expired is combinational from the count; count updates on the next edge.
// No backpressure: clear has priority over enable.
module mem_timeout_ctr #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(ACK_TIMEOUT - 1);

  logic [W-1:0] cnt;

  // Count wait cycles; restart from zero on entry to a new access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The current cycle is the ACK_TIMEOUT-th wait cycle: counting it makes the count reach ACK_TIMEOUT.
  assign expired = (cnt == LAST);

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results to writeback, runs LD/ST against a req/ack data memory.
// Latency: 1 cycle for non-memory ops; LD/ST retire the cycle after dmem_ack or after ACK_TIMEOUT wait cycles.
// Backpressure: ex_ready is low while an access is outstanding and permanently after HALT.
module mem_stage import cpu_pkg::*; #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_valid,
  output logic       ex_ready,
  input  logic [7:0] instr,
  input  logic [7:0] alu_result,
  input  logic [7:0] write_data,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic [7:0] dmem_addr,
  output logic [7:0] dmem_wdata,
  input  logic       dmem_ack,
  input  logic [7:0] dmem_rdata,
  output logic       wb_valid,
  output logic       wb_we,
  output logic [1:0] wb_rd,
  output logic [7:0] wb_data,
  output logic       halted,
  output logic       mem_err
);

  mem_state_t state, state_d;

  logic [1:0] op, rs, rt;
  logic       xfer;
  logic       unused_bits;

  // captured instruction fields needed after the access completes
  logic [1:0] cap_rt, cap_rt_d;
  logic       cap_ld, cap_ld_d;

  logic       req_d, we_d, wb_valid_d, wb_we_d, halted_d, mem_err_d;
  logic [7:0] addr_d, wdata_d, wb_data_d;
  logic [1:0] wb_rd_d;

  logic ctr_clear, ctr_en, ctr_expired;

  assign op          = instr[7:6];
  assign rs          = instr[5:4];
  assign rt          = instr[3:2];
  assign unused_bits = ^instr[1:0];

  assign ex_ready = (state == ST_IDLE) && !halted;
  assign xfer     = ex_valid && ex_ready;

  mem_timeout_ctr #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (ctr_clear),
    .enable  (ctr_en),
    .expired (ctr_expired)
  );

  // Next-state and next-output decode; unassigned outputs fall back to 0, sticky flags hold.
  always_comb begin
    state_d    = state;
    cap_rt_d   = cap_rt;
    cap_ld_d   = cap_ld;
    req_d      = 1'b0;
    we_d       = 1'b0;
    addr_d     = 8'h00;
    wdata_d    = 8'h00;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_rd_d    = 2'b00;
    wb_data_d  = 8'h00;
    halted_d   = halted;
    mem_err_d  = mem_err;
    ctr_clear  = 1'b0;
    ctr_en     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (xfer) begin
          cap_rt_d = rt;
          cap_ld_d = (op == OP_I) && (rs == SUB_LD);
          if (is_mem_op(op, rs)) begin
            state_d   = ST_MEM;
            req_d     = 1'b1;
            we_d      = (rs == SUB_ST);
            addr_d    = alu_result;
            wdata_d   = write_data;
            ctr_clear = 1'b1;
          end else begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rt;
            unique case (op)
              OP_R, OP_I: begin
                // only ADDI and CMP reach here among I-type ops
                wb_we_d   = 1'b1;
                wb_data_d = alu_result;
              end
              OP_HALT: halted_d = 1'b1;
              default: ;
            endcase
          end
        end
      end

      ST_MEM: begin
        if (dmem_ack) begin
          // ack wins over a timeout landing in the same cycle
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = cap_rt;
          wb_we_d    = cap_ld;
          wb_data_d  = cap_ld ? dmem_rdata : 8'h00;
        end else if (ctr_expired) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = cap_rt;
          mem_err_d  = 1'b1;
        end else begin
          req_d   = 1'b1;
          we_d    = dmem_we;
          addr_d  = dmem_addr;
          wdata_d = dmem_wdata;
          ctr_en  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, captured fields and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cap_rt     <= 2'b00;
      cap_ld     <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 8'h00;
      dmem_wdata <= 8'h00;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= 2'b00;
      wb_data    <= 8'h00;
      halted     <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      state      <= state_d;
      cap_rt     <= cap_rt_d;
      cap_ld     <= cap_ld_d;
      dmem_req   <= req_d;
      dmem_we    <= we_d;
      dmem_addr  <= addr_d;
      dmem_wdata <= wdata_d;
      wb_valid   <= wb_valid_d;
      wb_we      <= wb_we_d;
      wb_rd      <= wb_rd_d;
      wb_data    <= wb_data_d;
      halted     <= halted_d;
      mem_err    <= mem_err_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU ops, LD/ST handshakes, timeout, reset mid-access, HALT.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Expected values are hand-computed constants.
module tb_mem_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_valid;
  logic       ex_ready;
  logic [7:0] instr, alu_result, write_data;
  logic       dmem_req, dmem_we, dmem_ack;
  logic [7:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic       wb_valid, wb_we;
  logic [1:0] wb_rd;
  logic [7:0] wb_data;
  logic       halted, mem_err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage #(.ACK_TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .instr      (instr),
    .alu_result (alu_result),
    .write_data (write_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .wb_valid   (wb_valid),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .halted     (halted),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present one instruction for a single cycle; returns just after the transfer edge
  task automatic issue(input logic [7:0] i, input logic [7:0] a, input logic [7:0] w);
    ex_valid   = 1'b1;
    instr      = i;
    alu_result = a;
    write_data = w;
    step();
    ex_valid   = 1'b0;
    instr      = 8'h00;
    alu_result = 8'h00;
    write_data = 8'h00;
  endtask

  task automatic check_wb(input string tag, input logic v, input logic we,
                          input logic [1:0] rd, input logic [7:0] d);
    check({tag, "_vld"},  wb_valid, v);
    check({tag, "_we"},   wb_we,    we);
    check({tag, "_rd"},   wb_rd,    rd);
    check({tag, "_data"}, wb_data,  d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; ex_valid = 1'b0; instr = 8'h00; alu_result = 8'h00;
    write_data = 8'h00; dmem_ack = 1'b0; dmem_rdata = 8'h00;

    // reset state
    #1;
    check("rst_req",    dmem_req,   1'b0);
    check("rst_addr",   dmem_addr,  8'h00);
    check_wb("rst_wb", 1'b0, 1'b0, 2'b00, 8'h00);
    check("rst_halted", halted,     1'b0);
    check("rst_err",    mem_err,    1'b0);
    step(); step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rdy", ex_ready, 1'b1);
    step();

    // ADD rt=01
    issue(8'h04, 8'h12, 8'h00);
    check_wb("add", 1'b1, 1'b1, 2'b01, 8'h12);
    step();
    check("add_pulse", wb_valid, 1'b0);

    // jump rt=11: retires without write
    issue(8'h8C, 8'h44, 8'h00);
    check_wb("jmp", 1'b1, 1'b0, 2'b11, 8'h00);
    step();

    // CMP rt=01
    issue(8'h74, 8'h55, 8'h00);
    check_wb("cmp", 1'b1, 1'b1, 2'b01, 8'h55);
    check("cmp_req", dmem_req, 1'b0);
    step();

    // LD, ack three cycles after req rises
    issue(8'h58, 8'h20, 8'h00);
    for (int k = 0; k < 3; k++) begin
      check("ld_req",  dmem_req,  1'b1);
      check("ld_we",   dmem_we,   1'b0);
      check("ld_addr", dmem_addr, 8'h20);
      check("ld_rdy",  ex_ready,  1'b0);
      check("ld_wb",   wb_valid,  1'b0);
      step();
    end
    check("ld_req3", dmem_req, 1'b1);
    dmem_ack = 1'b1; dmem_rdata = 8'hA5;
    step();
    dmem_ack = 1'b0; dmem_rdata = 8'h00;
    check("ld_req_drop", dmem_req, 1'b0);
    check_wb("ld", 1'b1, 1'b1, 2'b10, 8'hA5);
    check("ld_err", mem_err, 1'b0);
    step();
    check("ld_pulse", wb_valid, 1'b0);
    check("ld_rdy_back", ex_ready, 1'b1);

    // ST, ack after one cycle
    issue(8'h6C, 8'h31, 8'h7E);
    check("st_req",   dmem_req,   1'b1);
    check("st_we",    dmem_we,    1'b1);
    check("st_addr",  dmem_addr,  8'h31);
    check("st_wdata", dmem_wdata, 8'h7E);
    step();
    check("st_hold",  dmem_wdata, 8'h7E);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    check_wb("st", 1'b1, 1'b0, 2'b11, 8'h00);
    check("st_req_drop", dmem_req, 1'b0);
    step();

    // LD acked in the last allowed (15th) wait cycle: success
    issue(8'h58, 8'h40, 8'h00);
    for (int k = 0; k < 14; k++) step();
    check("edge_req", dmem_req, 1'b1);
    dmem_ack = 1'b1; dmem_rdata = 8'h3C;
    step();
    dmem_ack = 1'b0; dmem_rdata = 8'h00;
    check_wb("edge", 1'b1, 1'b1, 2'b10, 8'h3C);
    check("edge_err", mem_err, 1'b0);
    step();

    // LD never acked: aborts after 15 request cycles
    issue(8'h58, 8'h20, 8'h00);
    n = 0;
    while (dmem_req && n < 40) begin
      if (wb_valid) check("to_early_wb", wb_valid, 1'b0);
      n++;
      step();
    end
    check("to_cycles", n, 15);
    check_wb("to", 1'b1, 1'b0, 2'b10, 8'h00);
    check("to_err", mem_err, 1'b1);
    step();
    check("to_pulse", wb_valid, 1'b0);

    // next ADD retires normally, error stays sticky
    issue(8'h04, 8'h99, 8'h00);
    check_wb("add2", 1'b1, 1'b1, 2'b01, 8'h99);
    check("add2_err", mem_err, 1'b1);
    step();

    // reset in the middle of an LD wait
    issue(8'h58, 8'h20, 8'h00);
    step();
    check("rl_req_pre", dmem_req, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rl_req",  dmem_req, 1'b0);
    check("rl_err",  mem_err,  1'b0);
    check("rl_wb",   wb_valid, 1'b0);
    step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rl_rdy", ex_ready, 1'b1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (wb_valid || mem_err) n++;
      step();
    end
    check("rl_no_retire", n, 0);

    // HALT, then further instructions are ignored
    issue(8'hC0, 8'h00, 8'h00);
    check_wb("halt", 1'b1, 1'b0, 2'b00, 8'h00);
    check("halt_flag", halted,   1'b1);
    check("halt_rdy",  ex_ready, 1'b0);
    ex_valid = 1'b1; instr = 8'h04; alu_result = 8'h12;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (wb_valid || dmem_req || ex_ready) n++;
    end
    ex_valid = 1'b0;
    check("halt_ignore", n, 0);
    check("halt_sticky", halted, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
